// File: rtl/or_window_accum_pkg.sv
// rtl/or_window_accum_pkg.sv - shared state encoding for the windowed OR accumulator
package or_window_accum_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/or_window_accum_or_reduce.sv
// rtl/or_window_accum_or_reduce.sv - parametrised N-input OR reduction
module or_reduce #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] data,
    output logic             any
);

    always_comb begin
        any = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            any = any | data[i];
        end
    end

endmodule

// File: rtl/or_window_accum.sv
// rtl/or_window_accum.sv - sticky bitwise OR over a window of accepted words
module or_window_accum
    import or_window_accum_pkg::*;
#(
    parameter  int WIDTH  = 16,
    parameter  int WINDOW = 4,
    localparam int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_any,
    output logic [CNT_W-1:0] out_count
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_inc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;
    logic [WIDTH-1:0] out_data_r;
    logic [CNT_W-1:0] out_count_r;
    logic             accept;
    logic             close;

    assign in_ready  = (state == ST_ACCUM);
    assign out_valid = (state == ST_HOLD);
    assign accept    = in_valid & in_ready;
    assign acc_inc   = acc | in_data;
    assign count_inc = count + CNT_W'(1);

    // A flush only closes a window that would hold at least one word.
    assign close = in_ready &&
                   ((accept && (count_inc == CNT_W'(WINDOW))) ||
                    (flush && ((|count) || accept)));

    always_comb begin
        state_next = state;
        case (state)
            ST_ACCUM: if (close)     state_next = ST_HOLD;
            ST_HOLD:  if (out_ready) state_next = ST_ACCUM;
            default:                 state_next = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // The accumulator is cleared as soon as its result moves to the output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc         <= '0;
            count       <= '0;
            out_data_r  <= '0;
            out_count_r <= '0;
        end else if (state == ST_ACCUM) begin
            if (close) begin
                out_data_r  <= accept ? acc_inc : acc;
                out_count_r <= accept ? count_inc : count;
                acc         <= '0;
                count       <= '0;
            end else if (accept) begin
                acc   <= acc_inc;
                count <= count_inc;
            end
        end else if (out_ready) begin
            out_data_r  <= '0;
            out_count_r <= '0;
        end
    end

    assign out_data  = out_data_r;
    assign out_count = out_count_r;

    or_reduce #(
        .WIDTH(WIDTH)
    ) u_or_reduce (
        .data(out_data_r),
        .any (out_any)
    );

endmodule

// File: tb/tb_or_window_accum.sv
// tb/tb_or_window_accum.sv - randomized and directed checks of or_window_accum against a queue model
module tb_or_window_accum;

    localparam int WIDTH  = 16;
    localparam int WINDOW = 4;
    localparam int CNT_W  = $clog2(WINDOW + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_any;
    logic [CNT_W-1:0] out_count;

    or_window_accum #(
        .WIDTH (WIDTH),
        .WINDOW(WINDOW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_any  (out_any),
        .out_count(out_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference: the open window is a queue of accepted words; a result is the OR of that queue.
    logic [WIDTH-1:0] win_q[$];
    bit               m_hold = 1'b0;
    logic [WIDTH-1:0] m_data = '0;
    int               m_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                win_q.delete();
                m_hold  = 1'b0;
                m_data  = '0;
                m_count = 0;
            end else if (m_hold) begin
                if (out_ready) begin
                    m_hold  = 1'b0;
                    m_data  = '0;
                    m_count = 0;
                end
            end else begin
                if (in_valid) win_q.push_back(in_data);
                if (win_q.size() == WINDOW || (flush && win_q.size() > 0)) begin
                    m_data = '0;
                    foreach (win_q[i]) m_data = m_data | win_q[i];
                    m_count = win_q.size();
                    m_hold  = 1'b1;
                    win_q.delete();
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("model_out_valid", 32'(out_valid), 32'(m_hold));
                check("model_in_ready", 32'(in_ready), 32'(!m_hold));
                check("model_out_data", 32'(out_data), 32'(m_data));
                check("model_out_count", 32'(out_count), 32'(m_count));
                check("model_out_any", 32'(out_any), 32'(m_data != '0));
            end
        end
    end

    task automatic cyc(input bit v, input logic [WIDTH-1:0] d, input bit f, input bit r, input bit rs);
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = r;
        reset     = rs;
        @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input string name, input bit v, input logic [WIDTH-1:0] d,
                              input int c, input bit a);
        check({name, "_valid"}, 32'(out_valid), 32'(v));
        check({name, "_ready"}, 32'(in_ready), 32'(!v));
        check({name, "_data"}, 32'(out_data), 32'(d));
        check({name, "_count"}, 32'(out_count), 32'(c));
        check({name, "_any"}, 32'(out_any), 32'(a));
    endtask

    initial begin
        cyc(0, '0, 0, 0, 1);
        chk_en = 1'b1;
        cyc(0, '0, 0, 0, 1);
        expect_out("reset", 0, 16'h0000, 0, 0);

        // Full window with consumer ready
        cyc(1, 16'h0001, 0, 1, 0);
        cyc(1, 16'h0010, 0, 1, 0);
        cyc(1, 16'h0100, 0, 1, 0);
        cyc(1, 16'h1000, 0, 1, 0);
        expect_out("win4", 1, 16'h1111, 4, 1);
        cyc(0, '0, 0, 1, 0);
        expect_out("win4_release", 0, 16'h0000, 0, 0);

        // Early flush, then flush on an empty window
        cyc(1, 16'h00F0, 0, 0, 0);
        cyc(1, 16'h0F00, 0, 0, 0);
        cyc(0, '0, 1, 0, 0);
        expect_out("flush2", 1, 16'h0FF0, 2, 1);
        cyc(0, '0, 0, 1, 0);
        cyc(0, '0, 1, 1, 0);
        expect_out("flush_empty", 0, 16'h0000, 0, 0);

        // Backpressure: producer waits through HOLD
        cyc(1, 16'h0003, 0, 0, 0);
        cyc(1, 16'h0030, 0, 0, 0);
        cyc(1, 16'h0300, 0, 0, 0);
        cyc(1, 16'h3000, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 16'hFFFF, 0, 0, 0);
            expect_out("hold_stable", 1, 16'h3333, 4, 1);
        end
        cyc(1, 16'hFFFF, 0, 1, 0);
        expect_out("hold_release", 0, 16'h0000, 0, 0);
        cyc(1, 16'hFFFF, 0, 0, 0);
        cyc(1, 16'h0001, 0, 0, 0);
        cyc(1, 16'h0002, 0, 0, 0);
        cyc(1, 16'h0004, 0, 0, 0);
        expect_out("after_hold", 1, 16'hFFFF, 4, 1);
        cyc(0, '0, 0, 1, 0);

        // All-zero window
        for (int i = 0; i < 4; i++) cyc(1, 16'h0000, 0, 0, 0);
        expect_out("zeros", 1, 16'h0000, 4, 0);
        cyc(0, '0, 0, 1, 0);

        // Reset while holding discards the result
        cyc(1, 16'h0001, 0, 0, 0);
        cyc(1, 16'h0010, 0, 0, 0);
        cyc(1, 16'h0100, 0, 0, 0);
        cyc(1, 16'h1000, 0, 0, 0);
        expect_out("pre_reset", 1, 16'h1111, 4, 1);
        cyc(0, '0, 0, 0, 1);
        expect_out("reset_hold", 0, 16'h0000, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 16'h0002, 0, 0, 0);
        expect_out("post_reset", 1, 16'h0002, 4, 1);
        cyc(0, '0, 0, 1, 0);

        // Flush coinciding with the completing word
        cyc(1, 16'h0800, 0, 0, 0);
        cyc(1, 16'h0080, 0, 0, 0);
        cyc(1, 16'h0008, 0, 0, 0);
        cyc(1, 16'h8000, 1, 0, 0);
        expect_out("flush_full", 1, 16'h8888, 4, 1);
        cyc(0, '0, 0, 1, 0);
        cyc(0, '0, 0, 0, 0);
        expect_out("no_extra", 0, 16'h0000, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            logic [WIDTH-1:0] d;
            d = ($urandom_range(0, 5) == 0) ? '0 : WIDTH'($urandom);
            cyc($urandom_range(0, 3) != 0, d, $urandom_range(0, 7) == 0,
                $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
